load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  CPU-side initiator for the word-wide data memory: accepts one load/store request at a time,
//  drives DataAddr/DataIn/DataMemRW, samples DataOut, and returns a response.
//  Handles byte/half/word sizes, sign/zero extension, and read-modify-write for sub-word stores.
//  Misaligned or illegal requests are rejected; memory is never touched for them.
// PARAMETERS
//  MEM_LAT  1  cycles DataAddr is held before DataOut is sampled (>=1)
// PORTS
//  CLK        in   1   clock, all state on rising edge
//  Reset      in   1   synchronous, active-high reset
//  ReqValid   in   1   request present
//  ReqReady   out  1   unit idle; request accepted when ReqValid&&ReqReady at edge
//  ReqWrite   in   1   1=store, 0=load
//  ReqSize    in   2   00=byte, 01=half, 10=word, 11=illegal
//  ReqSigned  in   1   loads: 1=sign-extend, 0=zero-extend; ignored for stores
//  ReqAddr    in   32  byte address
//  ReqWData   in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  RespValid  out  1   one-cycle response strobe
//  RespData   out  32  load result / word written by store / 0 on error
//  RespErr    out  1   valid with RespValid: misaligned or illegal size
//  DataAddr   out  32  to memory: {addr[31:2],2'b00}
//  DataIn     out  32  to memory: word to write
//  DataMemRW  out  1   to memory: 1=write, 0=read
//  DataOut    in   32  from memory: read word, little-endian (byte0 = [7:0])
// BEHAVIOUR
//  Reset: state IDLE; ReqReady=1; RespValid=0, RespData=0, RespErr=0;
//   DataAddr=0, DataIn=0, DataMemRW=0; latency counter=0. All outputs registered.
//  FSM: IDLE -> READ | WRITE | RESP(err); READ -> READ (cnt<MEM_LAT) | WRITE (sub-word store)
//   | RESP (load); WRITE -> RESP; RESP -> IDLE. ReqReady=1 only in IDLE.
//  Accept (cycle T): latch Write/Size/Signed/Addr/WData. Error if Size=11, or half with
//   addr[0]=1, or word with addr[1:0]!=0 -> RESP at T+1 with RespErr=1, RespData=0, DataMemRW=0.
//  Load: READ T+1..T+MEM_LAT, DataMemRW=0, DataAddr stable; DataOut sampled at end of
//   cycle T+MEM_LAT; RespValid=1 at T+MEM_LAT+1. Byte lane = addr[1:0], half lane = addr[1];
//   extend from bit 7/15 if Signed, else zero.
//  Word store: WRITE at T+1 (DataMemRW=1, DataIn=WData, one cycle); RESP at T+2.
//  Byte/half store: READ as load, merge WData lane into sampled word (other bytes kept),
//   WRITE at T+MEM_LAT+1, RESP at T+MEM_LAT+2; RespData = merged word.
//  DataMemRW high exactly one cycle per store; DataAddr/DataIn change only on the same edge
//   DataMemRW rises and are held through the following cycle.
//  RespValid high exactly one cycle; no backpressure. ReqValid ignored outside IDLE.
//  Next request accepted earliest in the cycle after RESP.
//  Reset mid-operation: abort at next edge to reset values; pending RMW never writes.
//  Address arithmetic: no carry into upper bits; addr 0xFFFFFFFC word access legal.
// TESTING
//  Reset held 2 cycles mid sub-word store -> DataMemRW never 1, outputs = reset values.
//  Mem[8..11]=0x8899AABB; load word addr 8 -> RespData=0x8899AABB at T+MEM_LAT+1, RespErr=0.
//  Same mem, load byte addr 0x0A signed -> 0xFFFFFF99; unsigned -> 0x00000099; half 0x0A signed -> 0xFFFF8899.
//  Store byte 0x5C to addr 9 -> one write of 0x8899 5CBB to DataAddr 8 at T+MEM_LAT+1; RespData=0x88995CBB.
//  Load half addr 0x0B and word addr 0x06 and Size=11 -> RespErr=1, RespData=0, no memory write.
//  Back-to-back ReqValid held high with word stores -> accepts every 3rd cycle, ReqReady low in between.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half/word access to a word-wide data memory.
// Sub-word stores do a read-modify-write; misaligned or illegal requests never touch memory.
module load_store_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespErr,
  output logic [31:0] DataAddr,
  output logic [31:0] DataIn,
  output logic        DataMemRW,
  input  logic [31:0] DataOut
);
  localparam int CntW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CntW-1:0] LatLimit = CntW'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsuState;

  lsuState         state;
  logic [CntW-1:0] latCnt;
  logic            isStore;
  logic [1:0]      size;
  logic            signedLoad;
  logic [1:0]      addrLo;
  logic [15:0]     storeData;

  logic            reqErr;
  logic [7:0]      laneByte;
  logic [15:0]     laneHalf;
  logic [31:0]     loadResult;
  logic [31:0]     mergedWord;

  always_comb begin
    reqErr = (ReqSize == 2'b11) ||
             (ReqSize == 2'b01 && ReqAddr[0]) ||
             (ReqSize == 2'b10 && ReqAddr[1:0] != 2'b00);
  end

  // Load lane extraction and extension from the word currently on DataOut
  always_comb begin
    laneByte = DataOut[{addrLo, 3'b000} +: 8];
    laneHalf = DataOut[{addrLo[1], 4'b0000} +: 16];
    case (size)
      2'b00:   loadResult = {{24{signedLoad & laneByte[7]}}, laneByte};
      2'b01:   loadResult = {{16{signedLoad & laneHalf[15]}}, laneHalf};
      default: loadResult = DataOut;
    endcase
  end

  // Sub-word store merge: replace only the addressed byte lanes of the read word
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gMerge
      localparam logic [1:0] Lane = 2'(gi);
      logic       hit;
      logic [7:0] src;
      assign hit = (size == 2'b00) ? (addrLo == Lane) : (addrLo[1] == Lane[1]);
      assign src = (size == 2'b00 || !Lane[0]) ? storeData[7:0] : storeData[15:8];
      assign mergedWord[8*gi +: 8] = hit ? src : DataOut[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      ReqReady   <= 1'b1;
      RespValid  <= 1'b0;
      RespData   <= 32'd0;
      RespErr    <= 1'b0;
      DataAddr   <= 32'd0;
      DataIn     <= 32'd0;
      DataMemRW  <= 1'b0;
      latCnt     <= '0;
      isStore    <= 1'b0;
      size       <= 2'b00;
      signedLoad <= 1'b0;
      addrLo     <= 2'b00;
      storeData  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            ReqReady   <= 1'b0;
            isStore    <= ReqWrite;
            size       <= ReqSize;
            signedLoad <= ReqSigned;
            addrLo     <= ReqAddr[1:0];
            storeData  <= ReqWData[15:0];
            if (reqErr) begin
              state     <= RESP;
              RespValid <= 1'b1;
              RespErr   <= 1'b1;
              RespData  <= 32'd0;
            end else if (ReqWrite && ReqSize == 2'b10) begin
              state     <= WRITE;
              DataAddr  <= {ReqAddr[31:2], 2'b00};
              DataIn    <= ReqWData;
              DataMemRW <= 1'b1;
            end else begin
              state    <= READ;
              DataAddr <= {ReqAddr[31:2], 2'b00};
              latCnt   <= CntW'(1);
            end
          end
        end
        READ: begin
          if (latCnt < LatLimit) begin
            latCnt <= latCnt + 1'b1;
          end else if (isStore) begin
            state     <= WRITE;
            DataIn    <= mergedWord;
            DataMemRW <= 1'b1;
          end else begin
            state     <= RESP;
            RespValid <= 1'b1;
            RespErr   <= 1'b0;
            RespData  <= loadResult;
          end
        end
        WRITE: begin
          // DataAddr/DataIn stay put through the response cycle
          state     <= RESP;
          DataMemRW <= 1'b0;
          RespValid <= 1'b1;
          RespErr   <= 1'b0;
          RespData  <= DataIn;
        end
        RESP: begin
          state     <= IDLE;
          RespValid <= 1'b0;
          RespErr   <= 1'b0;
          ReqReady  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model with a per-cycle compare process,
// directed literal cases, then randomized traffic with occasional resets.
module tb_load_store_unit;
  localparam int MEM_LAT = 1;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqWrite = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqSigned = 1'b0;
  logic [31:0] ReqAddr = 32'd0;
  logic [31:0] ReqWData = 32'd0;
  logic [31:0] DataOut = 32'd0;
  logic        ReqReady;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespErr;
  logic [31:0] DataAddr;
  logic [31:0] DataIn;
  logic        DataMemRW;

  load_store_unit #(.MEM_LAT(MEM_LAT)) dut (
    .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .RespValid(RespValid),
    .RespData(RespData), .RespErr(RespErr), .DataAddr(DataAddr),
    .DataIn(DataIn), .DataMemRW(DataMemRW), .DataOut(DataOut)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Physical memory (written only by the DUT) and the model's own view of it
  logic [31:0] mem    [logic [29:0]];
  logic [31:0] shadow [logic [29:0]];
  int wrCount = 0;

  function automatic logic [31:0] dflt(input logic [29:0] a);
    return 32'(a) * 32'h9E3779B1 + 32'h1357_2468;
  endfunction
  function automatic logic [31:0] memRd(input logic [29:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] shadowRd(input logic [29:0] a);
    return shadow.exists(a) ? shadow[a] : dflt(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory: write at the edge that ends a DataMemRW cycle, read data settles just after each edge
  always @(posedge CLK) begin
    if (DataMemRW === 1'b1) begin
      mem[DataAddr[31:2]] = DataIn;
      wrCount++;
    end
    #1 DataOut = memRd(DataAddr[31:2]);
  end

  // Model state
  int cyc = 0;
  int busyUntil = -1;
  int respCycle = -1;
  int wrCycle = -1;
  logic [31:0] expRespData, expWrAddr, expWrData;
  logic        expRespErr;
  logic        known = 1'b0;
  logic        resetNext = 1'b0;
  int acceptCnt = 0;
  int respSeen = 0;
  logic [31:0] lastDutData, lastModelData;
  logic        lastDutErr;

  // Compare process: one check pass per cycle, then model acceptance for this cycle
  always @(negedge CLK) begin
    logic        err;
    logic [29:0] wa;
    logic [31:0] word, shifted, mask;
    int          sh;
    if (known) begin
      chk("ReqReady", 32'(ReqReady), 32'(cyc > busyUntil));
      chk("RespValid", 32'(RespValid), 32'(cyc == respCycle));
      if (cyc == respCycle) begin
        chk("RespErr", 32'(RespErr), 32'(expRespErr));
        chk("RespData", RespData, expRespData);
        lastModelData = expRespData;
      end
      chk("DataMemRW", 32'(DataMemRW), 32'(cyc == wrCycle));
      if (cyc == wrCycle) begin
        chk("DataAddr_wr", DataAddr, expWrAddr);
        chk("DataIn_wr", DataIn, expWrData);
        shadow[expWrAddr[31:2]] = expWrData;
      end
      if (wrCycle >= 0 && cyc == wrCycle + 1 && !resetNext) begin
        chk("DataAddr_hold", DataAddr, expWrAddr);
        chk("DataIn_hold", DataIn, expWrData);
      end
      if (resetNext) begin
        chk("rst_RespData", RespData, 32'd0);
        chk("rst_RespErr", 32'(RespErr), 32'd0);
        chk("rst_DataAddr", DataAddr, 32'd0);
        chk("rst_DataIn", DataIn, 32'd0);
      end
      if (RespValid === 1'b1) begin
        respSeen++;
        lastDutData = RespData;
        lastDutErr  = RespErr;
      end
    end
    resetNext = 1'b0;
    if (Reset) begin
      known = 1'b1;
      resetNext = 1'b1;
      busyUntil = cyc;
      respCycle = -1;
      wrCycle = -1;
    end else if (known && ReqValid && cyc > busyUntil) begin
      acceptCnt++;
      err = (ReqSize == 2'b11) || (ReqSize == 2'b01 && ReqAddr[0]) ||
            (ReqSize == 2'b10 && ReqAddr[1:0] != 2'b00);
      wa = ReqAddr[31:2];
      word = shadowRd(wa);
      expWrAddr = {ReqAddr[31:2], 2'b00};
      wrCycle = -1;
      expRespErr = 1'b0;
      if (err) begin
        respCycle = cyc + 1;
        expRespErr = 1'b1;
        expRespData = 32'd0;
      end else if (!ReqWrite) begin
        respCycle = cyc + MEM_LAT + 1;
        sh = (ReqSize == 2'b00) ? 8 * int'(ReqAddr[1:0]) : 16 * int'(ReqAddr[1]);
        shifted = word >> sh;
        if (ReqSize == 2'b00)
          expRespData = (ReqSigned && shifted[7]) ? (shifted | 32'hFFFFFF00) : (shifted & 32'hFF);
        else if (ReqSize == 2'b01)
          expRespData = (ReqSigned && shifted[15]) ? (shifted | 32'hFFFF0000) : (shifted & 32'hFFFF);
        else
          expRespData = word;
      end else if (ReqSize == 2'b10) begin
        wrCycle = cyc + 1;
        respCycle = cyc + 2;
        expWrData = ReqWData;
        expRespData = ReqWData;
      end else begin
        sh = (ReqSize == 2'b00) ? 8 * int'(ReqAddr[1:0]) : 16 * int'(ReqAddr[1]);
        mask = ((ReqSize == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        expWrData = (word & ~mask) | ((ReqWData << sh) & mask);
        wrCycle = cyc + MEM_LAT + 1;
        respCycle = cyc + MEM_LAT + 2;
        expRespData = expWrData;
      end
      busyUntil = respCycle;
    end
    cyc++;
  end

  task automatic doReq(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    int a0, r0;
    @(posedge CLK); #1;
    ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = d;
    a0 = acceptCnt;
    r0 = respSeen;
    for (int k = 0; k < 20 && acceptCnt == a0; k++) begin @(posedge CLK); #1; end
    ReqValid = 1'b0;
    if (acceptCnt == a0) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no accept want accept of addr %h", a);
    end
    for (int k = 0; k < 20 && respSeen == r0; k++) begin @(posedge CLK); #1; end
    if (respSeen == r0) begin
      total++; bad++;
      $display("FAIL resp_timeout: got no RespValid want RespValid for addr %h", a);
    end
    $display("req w=%0d size=%0d signed=%0d addr=%h wdata=%h -> data=%h err=%0d",
             w, sz, sg, a, d, lastDutData, lastDutErr);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, a0;
    mem[30'd2] = 32'h8899AABB;
    shadow[30'd2] = 32'h8899AABB;
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b0;

    doReq(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    chk("ld_word", lastDutData, 32'h8899AABB);
    chk("ld_word_err", 32'(lastDutErr), 32'd0);
    chk("model_ld_word", lastModelData, 32'h8899AABB);
    doReq(1'b0, 2'b00, 1'b1, 32'hA, 32'h0);
    chk("ld_byte_s", lastDutData, 32'hFFFFFF99);
    chk("model_ld_byte_s", lastModelData, 32'hFFFFFF99);
    doReq(1'b0, 2'b00, 1'b0, 32'hA, 32'h0);
    chk("ld_byte_u", lastDutData, 32'h00000099);
    doReq(1'b0, 2'b01, 1'b1, 32'hA, 32'h0);
    chk("ld_half_s", lastDutData, 32'hFFFF8899);

    w0 = wrCount;
    doReq(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000005C);
    chk("st_byte_resp", lastDutData, 32'h88995CBB);
    chk("model_st_byte", lastModelData, 32'h88995CBB);
    chk("st_byte_mem", memRd(30'd2), 32'h88995CBB);
    chk("st_byte_writes", 32'(wrCount - w0), 32'd1);

    w0 = wrCount;
    doReq(1'b0, 2'b01, 1'b0, 32'hB, 32'h0);
    chk("err_half_err", 32'(lastDutErr), 32'd1);
    chk("err_half_data", lastDutData, 32'd0);
    doReq(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    chk("err_word_err", 32'(lastDutErr), 32'd1);
    doReq(1'b1, 2'b11, 1'b0, 32'h4, 32'hDEADBEEF);
    chk("err_size_err", 32'(lastDutErr), 32'd1);
    chk("err_size_data", lastDutData, 32'd0);
    chk("err_no_write", 32'(wrCount - w0), 32'd0);

    doReq(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h12345678);
    doReq(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0);
    chk("top_word", lastDutData, 32'h12345678);

    // Reset held two cycles in the middle of a byte store
    @(posedge CLK); #1;
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b00; ReqAddr = 32'h10; ReqWData = 32'hAB;
    a0 = acceptCnt;
    for (int k = 0; k < 20 && acceptCnt == a0; k++) begin @(posedge CLK); #1; end
    ReqValid = 1'b0;
    w0 = wrCount;
    Reset = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    Reset = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    chk("rst_accepted", 32'(acceptCnt - a0), 32'd1);
    chk("rst_no_write", 32'(wrCount - w0), 32'd0);
    $display("reset mid byte store: writes=%0d", wrCount - w0);

    // Back-to-back word stores with ReqValid held high
    @(posedge CLK); #1;
    a0 = acceptCnt;
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10;
    for (int k = 0; k < 12; k++) begin
      ReqAddr = 32'($urandom_range(0, 15)) << 2;
      ReqWData = $urandom;
      @(posedge CLK); #1;
    end
    ReqValid = 1'b0;
    chk("b2b_accepts", 32'(acceptCnt - a0), 32'd4);
    $display("back-to-back word stores: accepted=%0d in 12 cycles", acceptCnt - a0);
    repeat (4) @(posedge CLK);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      @(posedge CLK); #1;
      Reset     = ($urandom_range(0, 199) == 0);
      ReqValid  = ($urandom_range(0, 9) < 6);
      ReqWrite  = 1'($urandom_range(0, 1));
      ReqSize   = 2'($urandom_range(0, 3));
      ReqSigned = 1'($urandom_range(0, 1));
      ReqAddr   = ($urandom_range(0, 15) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3)))
                                               : 32'($urandom_range(0, 63));
      ReqWData  = $urandom;
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
    ReqValid = 1'b0;
    repeat (8) @(posedge CLK);
    $display("random phase: accepted=%0d responses=%0d writes=%0d", acceptCnt, respSeen, wrCount);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
